// File: rtl/psx_pkg.sv
// Shared definitions for the PSX pad emulator: protocol byte values,
// FSM state encoding and the helpers that pick the reply byte and
// validate the host command byte.
package psx_pkg;

    localparam logic [7:0] PSX_CMD_START  = 8'h01;
    localparam logic [7:0] PSX_CMD_POLL   = 8'h42;
    localparam logic [7:0] PSX_DATA_READY = 8'h5A;
    localparam logic [7:0] PSX_IDLE_BYTE  = 8'hFF;
    localparam logic [7:0] PSX_ID_DIGITAL = 8'h41;

    localparam int PSX_FRAME_BYTES = 5;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SHIFT     = 3'd1,
        ACK_WAIT  = 3'd2,
        ACK_PULSE = 3'd3,
        IGNORE    = 3'd4
    } psx_state_t;

    // Reply byte for a given position in the frame; buttons are active-high
    // on the input but pressed buttons must read as 0 on the wire.
    function automatic logic [7:0] psx_tx_byte(input logic [2:0]  idx,
                                               input logic [15:0] btn,
                                               input logic [7:0]  id);
        logic [7:0] b;
        case (idx)
            3'd0:    b = PSX_IDLE_BYTE;
            3'd1:    b = id;
            3'd2:    b = PSX_DATA_READY;
            3'd3:    b = ~btn[7:0];
            3'd4:    b = ~btn[15:8];
            default: b = PSX_IDLE_BYTE;
        endcase
        return b;
    endfunction

    // Only the first two command bytes carry meaning; the rest are don't-care.
    function automatic logic psx_cmd_ok(input logic [2:0] idx,
                                        input logic [7:0] rx);
        logic ok;
        case (idx)
            3'd0:    ok = (rx == PSX_CMD_START);
            3'd1:    ok = (rx == PSX_CMD_POLL);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/psx_controller_emu_if.sv
// Serial link between the PSX host and the pad. The host is the master:
// it drives clock, attention and command; the pad answers with data/ack.
interface psx_controller_emu_if;

    logic psx_clk;
    logic psx_att;
    logic psx_cmd;
    logic data;
    logic ack;

    modport master (
        output psx_clk,
        output psx_att,
        output psx_cmd,
        input  data,
        input  ack
    );

    modport slave (
        input  psx_clk,
        input  psx_att,
        input  psx_cmd,
        output data,
        output ack
    );

endinterface

// File: rtl/psx_sync_edge.sv
// Multi-flop synchronizer for one asynchronous link input, with edge
// detection on the synchronized level. STAGES must be at least 2.
module psx_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_r;
    logic              prev_r;

    // Shift the raw input through the synchronizer and remember the last level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {STAGES{RESET_VAL}};
            prev_r <= RESET_VAL;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
            prev_r <= sync_r[STAGES-1];
        end
    end

    assign level = sync_r[STAGES-1];
    assign rise  = sync_r[STAGES-1] & ~prev_r;
    assign fall  = ~sync_r[STAGES-1] & prev_r;

endmodule

// File: rtl/psx_controller_emu.sv
// Digital PSX pad emulator. Oversamples the host link on the system clock,
// shifts out FF / ID / 5A / buttons while shifting in the host commands,
// and produces the inter-byte ack pulse. Buttons are frozen per frame.
module psx_controller_emu
    import psx_pkg::*;
#(
    parameter logic [7:0] ID_BYTE     = PSX_ID_DIGITAL,
    parameter int         ACK_DELAY   = 4,
    parameter int         ACK_LEN     = 4,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    psx_controller_emu_if.slave   link,
    input  logic [15:0]           buttons,
    output logic                  frame_done,
    output logic                  cmd_error
);

    localparam int TMR_MAX = (ACK_DELAY > ACK_LEN) ? ACK_DELAY : ACK_LEN;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;

    localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(ACK_DELAY - 1);
    localparam logic [TMR_W-1:0] LEN_LAST   = TMR_W'(ACK_LEN - 1);
    localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
    localparam logic [TMR_W-1:0] TMR_ZERO   = TMR_W'(0);
    localparam logic [2:0]       LAST_IDX   = 3'(PSX_FRAME_BYTES - 1);

    // Synchronized link inputs
    logic clk_level_s, clk_rise_s, clk_fall_s;
    logic att_level_s, att_rise_s, att_fall_s;
    logic cmd_level_s, cmd_rise_s, cmd_fall_s;
    logic unused_edges_s;

    // Frame state
    psx_state_t       state_r;
    logic [7:0]       tx_shift_r;
    logic [7:0]       rx_shift_r;
    logic [3:0]       bit_cnt_r;
    logic [2:0]       byte_idx_r;
    logic [TMR_W-1:0] timer_r;
    logic [15:0]      btn_r;
    logic             data_r;
    logic             ack_r;
    logic             frame_done_r;
    logic             cmd_error_r;

    logic [7:0]       rx_next_s;
    logic [2:0]       next_idx_s;

    psx_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_clk (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (link.psx_clk),
        .level (clk_level_s),
        .rise  (clk_rise_s),
        .fall  (clk_fall_s)
    );

    psx_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_att (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (link.psx_att),
        .level (att_level_s),
        .rise  (att_rise_s),
        .fall  (att_fall_s)
    );

    psx_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cmd (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (link.psx_cmd),
        .level (cmd_level_s),
        .rise  (cmd_rise_s),
        .fall  (cmd_fall_s)
    );

    // The clock level and command edges are not needed by the protocol.
    assign unused_edges_s = ^{clk_level_s, cmd_rise_s, cmd_fall_s};

    // Command byte as it will look once the current rising edge is absorbed.
    assign rx_next_s = {cmd_level_s, rx_shift_r[7:1]};

    // Next byte position, saturating at the last byte of the frame.
    always_comb begin
        next_idx_s = byte_idx_r;
        if (byte_idx_r < LAST_IDX) begin
            next_idx_s = byte_idx_r + 3'd1;
        end else begin
            next_idx_s = LAST_IDX;
        end
    end

    // Frame sequencer: byte shifting, command check, ack timing and abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            tx_shift_r   <= PSX_IDLE_BYTE;
            rx_shift_r   <= 8'h00;
            bit_cnt_r    <= 4'd0;
            byte_idx_r   <= 3'd0;
            timer_r      <= TMR_ZERO;
            btn_r        <= 16'h0000;
            data_r       <= 1'b1;
            ack_r        <= 1'b1;
            frame_done_r <= 1'b0;
            cmd_error_r  <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            cmd_error_r  <= 1'b0;
            if (att_rise_s) begin
                // Host ended the transaction: abort whatever was in flight.
                state_r    <= IDLE;
                data_r     <= 1'b1;
                ack_r      <= 1'b1;
                bit_cnt_r  <= 4'd0;
                byte_idx_r <= 3'd0;
                timer_r    <= TMR_ZERO;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (att_fall_s) begin
                            btn_r      <= buttons;
                            tx_shift_r <= PSX_IDLE_BYTE;
                            byte_idx_r <= 3'd0;
                            bit_cnt_r  <= 4'd0;
                            state_r    <= SHIFT;
                        end else begin
                            state_r    <= IDLE;
                        end
                    end
                    SHIFT: begin
                        if (clk_fall_s) begin
                            data_r     <= tx_shift_r[0];
                            tx_shift_r <= {1'b1, tx_shift_r[7:1]};
                        end else if (clk_rise_s) begin
                            rx_shift_r <= rx_next_s;
                            bit_cnt_r  <= bit_cnt_r + 4'd1;
                            if (bit_cnt_r == 4'd7) begin
                                timer_r <= TMR_ZERO;
                                if (!psx_cmd_ok(byte_idx_r, rx_next_s)) begin
                                    cmd_error_r <= 1'b1;
                                    data_r      <= 1'b1;
                                    state_r     <= IGNORE;
                                end else if (byte_idx_r >= LAST_IDX) begin
                                    frame_done_r <= 1'b1;
                                    data_r       <= 1'b1;
                                    state_r      <= IGNORE;
                                end else begin
                                    state_r <= ACK_WAIT;
                                end
                            end
                        end else begin
                            state_r <= SHIFT;
                        end
                    end
                    ACK_WAIT: begin
                        if (timer_r == DELAY_LAST) begin
                            timer_r <= TMR_ZERO;
                            ack_r   <= 1'b0;
                            state_r <= ACK_PULSE;
                        end else begin
                            timer_r <= timer_r + TMR_ONE;
                        end
                    end
                    ACK_PULSE: begin
                        if (timer_r == LEN_LAST) begin
                            timer_r    <= TMR_ZERO;
                            ack_r      <= 1'b1;
                            byte_idx_r <= next_idx_s;
                            tx_shift_r <= psx_tx_byte(next_idx_s, btn_r, ID_BYTE);
                            bit_cnt_r  <= 4'd0;
                            state_r    <= SHIFT;
                        end else begin
                            timer_r <= timer_r + TMR_ONE;
                        end
                    end
                    IGNORE: begin
                        data_r <= 1'b1;
                        ack_r  <= 1'b1;
                        if (att_level_s) begin
                            state_r <= IDLE;
                        end else begin
                            state_r <= IGNORE;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        data_r  <= 1'b1;
                        ack_r   <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign link.data  = data_r;
    assign link.ack   = ack_r;
    assign frame_done = frame_done_r;
    assign cmd_error  = cmd_error_r;

endmodule

// File: tb/tb_psx_controller_emu.sv
// Bench for the PSX pad emulator: a bit-banging host drives frames, a
// byte monitor and a pulse monitor compare the pad's replies against
// expected values queued by the stimulus.
`timescale 1ns/1ps
module tb_psx_controller_emu;
    import psx_pkg::*;

    localparam int ACK_DELAY   = 4;
    localparam int ACK_LEN     = 4;
    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 8;
    localparam int ACK_LAT     = SYNC_STAGES + 1 + ACK_DELAY;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] buttons;
    logic        frame_done;
    logic        cmd_error;

    psx_controller_emu_if ifc ();

    psx_controller_emu #(
        .ID_BYTE     (8'h41),
        .ACK_DELAY   (ACK_DELAY),
        .ACK_LEN     (ACK_LEN),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .link       (ifc),
        .buttons    (buttons),
        .frame_done (frame_done),
        .cmd_error  (cmd_error)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    int         ack_pulses = 0;
    int         ack_len    = 0;
    int         fd_cnt     = 0;
    int         ce_cnt     = 0;
    logic       fd_prev    = 1'b0;
    logic [7:0] mon_byte   = 8'h00;
    int         mon_bits   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Byte monitor: sample data on host rising edges, compare each full byte.
    initial begin
        forever begin
            @(posedge ifc.psx_clk or posedge ifc.psx_att);
            if (ifc.psx_att === 1'b1) begin
                mon_bits = 0;
            end else begin
                mon_byte = {ifc.data, mon_byte[7:1]};
                mon_bits++;
                if (mon_bits == 8) begin
                    mon_bits = 0;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL rx_byte: got %0h expected no byte", mon_byte);
                    end else begin
                        check("rx_byte", {24'd0, mon_byte}, {24'd0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    // Pulse monitor: ack width and count, frame_done / cmd_error counts.
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            ack_len = 0;
        end else if (ifc.ack === 1'b0) begin
            ack_len++;
        end else if (ack_len != 0) begin
            check("ack_len", ack_len, ACK_LEN);
            ack_pulses++;
            ack_len = 0;
        end
        if (frame_done === 1'b1) begin
            fd_cnt++;
            check("frame_done_width", {31'd0, fd_prev}, 32'd0);
        end
        if (cmd_error === 1'b1) begin
            ce_cnt++;
        end
        fd_prev = (frame_done === 1'b1);
    end

    // mode: 0 = no ack expected, 1 = check ack latency and wait it out,
    // 2 = return as soon as ack goes low.
    task automatic send_byte(input logic [7:0] cmd, input logic [7:0] exp,
                             input int nbits, input int mode, input string tag);
        int cnt;
        if (nbits == 8) exp_q.push_back(exp);
        for (int i = 0; i < nbits; i++) begin
            ifc.psx_clk = 1'b0;
            ifc.psx_cmd = cmd[i];
            tick(HALF);
            ifc.psx_clk = 1'b1;
            if (i != nbits - 1) tick(HALF);
        end
        if (mode == 0) begin
            tick(HALF + ACK_DELAY + ACK_LEN);
        end else begin
            cnt = 0;
            while (ifc.ack === 1'b1 && cnt < 40) begin
                tick(1);
                cnt++;
            end
            check({tag, "_ack_delay"}, cnt, ACK_LAT);
            if (mode == 1) begin
                cnt = 0;
                while (ifc.ack === 1'b0 && cnt < 40) begin
                    tick(1);
                    cnt++;
                end
                tick(2);
            end
        end
    endtask

    task automatic run_frame(input logic [39:0] cmds, input logic [39:0] exp, input int n_ack,
                             input logic [15:0] btn0, input logic [15:0] btn1,
                             input int want_fd, input int want_ce, input string tag);
        int a0, f0, c0;
        a0 = ack_pulses;
        f0 = fd_cnt;
        c0 = ce_cnt;
        buttons = btn0;
        ifc.psx_att = 1'b0;
        tick(HALF);
        for (int b = 0; b < 5; b++) begin
            send_byte(cmds[8*b +: 8], exp[8*b +: 8], 8, (b < n_ack) ? 1 : 0, tag);
            if (b == 0) buttons = btn1;
        end
        ifc.psx_att = 1'b1;
        tick(4 * HALF);
        check({tag, "_acks"}, ack_pulses - a0, n_ack);
        check({tag, "_frame_done"}, fd_cnt - f0, want_fd);
        check({tag, "_cmd_error"}, ce_cnt - c0, want_ce);
    endtask

    localparam logic [39:0] CMD_OK  = {8'h00, 8'h00, 8'h00, 8'h42, 8'h01};
    localparam logic [39:0] CMD_BAD = {8'h00, 8'h00, 8'h00, 8'h43, 8'h01};

    initial begin
        int f0;
        ifc.psx_clk = 1'b1;
        ifc.psx_att = 1'b1;
        ifc.psx_cmd = 1'b1;
        buttons     = 16'h0000;
        rst_n       = 1'b0;
        tick(3);
        check("reset_data", {31'd0, ifc.data}, 32'd1);
        check("reset_ack", {31'd0, ifc.ack}, 32'd1);
        check("reset_frame_done", {31'd0, frame_done}, 32'd0);
        check("reset_cmd_error", {31'd0, cmd_error}, 32'd0);
        check("reset_state", {29'd0, dut.state_r}, {29'd0, IDLE});
        rst_n = 1'b1;
        tick(4);

        // Nominal frame
        run_frame(CMD_OK, {8'hFF, 8'hEF, 8'h5A, 8'h41, 8'hFF}, 4, 16'h0010, 16'h0010, 1, 0, "nominal");

        // Bad poll byte, then a good frame
        run_frame(CMD_BAD, {8'hFF, 8'hFF, 8'hFF, 8'h41, 8'hFF}, 1, 16'h0010, 16'h0010, 0, 1, "badpoll");
        run_frame(CMD_OK, {8'hFF, 8'hEF, 8'h5A, 8'h41, 8'hFF}, 4, 16'h0010, 16'h0010, 1, 0, "recover");

        // Abort after byte 2, bit 3
        f0 = fd_cnt;
        buttons = 16'h0010;
        ifc.psx_att = 1'b0;
        tick(HALF);
        send_byte(8'h01, 8'hFF, 8, 1, "abort");
        send_byte(8'h42, 8'h41, 8, 1, "abort");
        send_byte(8'h00, 8'h00, 3, 0, "abort");
        check("abort_data_before", {31'd0, ifc.data}, 32'd0);
        ifc.psx_att = 1'b1;
        tick(SYNC_STAGES + 2);
        check("abort_state", {29'd0, dut.state_r}, {29'd0, IDLE});
        check("abort_data", {31'd0, ifc.data}, 32'd1);
        check("abort_ack", {31'd0, ifc.ack}, 32'd1);
        tick(4 * HALF);
        check("abort_frame_done", fd_cnt - f0, 32'd0);

        // Buttons frozen at attention fall
        run_frame(CMD_OK, {8'hFF, 8'hFF, 8'h5A, 8'h41, 8'hFF}, 4, 16'h0000, 16'hFFFF, 1, 0, "freeze");
        run_frame(CMD_OK, {8'h00, 8'h00, 8'h5A, 8'h41, 8'hFF}, 4, 16'hFFFF, 16'hFFFF, 1, 0, "pressed");

        // Reset while ack is low (data is 0: last bit of 0x41)
        buttons = 16'h0010;
        ifc.psx_att = 1'b0;
        tick(HALF);
        send_byte(8'h01, 8'hFF, 8, 1, "rst");
        send_byte(8'h42, 8'h41, 8, 2, "rst");
        check("rst_pre_ack", {31'd0, ifc.ack}, 32'd0);
        check("rst_pre_data", {31'd0, ifc.data}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_ack", {31'd0, ifc.ack}, 32'd1);
        check("rst_async_data", {31'd0, ifc.data}, 32'd1);
        check("rst_async_state", {29'd0, dut.state_r}, {29'd0, IDLE});
        ifc.psx_att = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(4);
        run_frame(CMD_OK, {8'hFF, 8'hEF, 8'h5A, 8'h41, 8'hFF}, 4, 16'h0010, 16'h0010, 1, 0, "postrst");

        // Back-to-back frames
        f0 = fd_cnt;
        run_frame(CMD_OK, {8'h7F, 8'hFE, 8'h5A, 8'h41, 8'hFF}, 4, 16'h8001, 16'h8001, 1, 0, "b2b_a");
        run_frame(CMD_OK, {8'h7F, 8'hFE, 8'h5A, 8'h41, 8'hFF}, 4, 16'h8001, 16'h8001, 1, 0, "b2b_b");
        check("b2b_frame_done", fd_cnt - f0, 32'd2);

        check("sb_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
